// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and instruction field helpers for alu_seq
package alu_pkg;
  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_ADDI = 4'hE;
  localparam logic [3:0] OP_LI   = 4'hF;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic logic [3:0] f_op(input logic [7:0] i);
    return i[7:4];
  endfunction
  function automatic logic [3:0] f_imm4(input logic [7:0] i);
    return i[3:0];
  endfunction
  function automatic logic [1:0] f_imm2(input logic [7:0] i);
    return i[1:0];
  endfunction
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: iterative one-bit-per-cycle logical shifter; done marks the final step
module alu_shifter import alu_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              left,
  input  logic [DATA_W-1:0] val,
  input  logic [SH_W-1:0]   amt,
  output logic              done,
  output logic [DATA_W-1:0] res
);
  logic [SH_W-1:0]   cnt;
  logic [DATA_W-1:0] work;
  logic              dir;
  assign done = cnt == SH_W'(1);
  assign res  = dir ? work << 1 : work >> 1;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt  <= '0;
      work <= '0;
      dir  <= 1'b0;
    end else if (load) begin
      cnt  <= amt;
      work <= val;
      dir  <= left;
    end else if (cnt != '0) begin
      cnt  <= cnt - SH_W'(1);
      work <= res;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked 16-opcode ALU with iterative shifts; define ALU_SAT_EN for saturating ADD/ADDI
module alu_seq import alu_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        instruction,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic              jump,
  output logic              overflow,
  output logic              zero,
  output logic              busy
);
  state_t            state, state_nx;
  logic [3:0]        op;
  logic [SH_W-1:0]   k;
  logic [DATA_W-1:0] imm2_x, imm4_x, a, b, sum, sat, res, sh_res;
  logic              accept, long_shift, ovf, res_jump, sh_done;
  assign op         = f_op(instruction);
  assign k          = in0[SH_W-1:0];
  assign busy       = state == SHIFT;
  assign in_ready   = state == IDLE && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign long_shift = (op == OP_SLL || op == OP_SRL) && k != '0;
  assign imm2_x     = DATA_W'($signed(f_imm2(instruction)));
  assign imm4_x     = DATA_W'($signed(f_imm4(instruction)));
  alu_shifter #(.DATA_W(DATA_W), .SH_W(SH_W)) u_shifter (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept && long_shift),
    .left (op == OP_SLL),
    .val  (in1),
    .amt  (k),
    .done (sh_done),
    .res  (sh_res)
  );
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept && long_shift ? SHIFT : IDLE;
    else               state_nx = sh_done ? IDLE : SHIFT;
  end
  // ADD and ADDI share one adder; ADDI takes in1 + sext(imm2)
  always_comb begin
    a   = op == OP_ADDI ? in1 : in0;
    b   = op == OP_ADDI ? imm2_x : in1;
    sum = a + b;
    sat = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    ovf = (op == OP_ADD || op == OP_ADDI) && a[DATA_W-1] == b[DATA_W-1] && sum[DATA_W-1] != a[DATA_W-1];
  end
  always_comb begin
    res      = '0;
    res_jump = 1'b0;
    case (op)
      OP_MOV:          res = in0;
`ifdef ALU_SAT_EN
      OP_ADD, OP_ADDI: res = ovf ? sat : sum;
`else
      OP_ADD, OP_ADDI: res = sum;
`endif
      OP_AND:          res = in0 & in1;
      OP_NOT:          res = ~in0;
      OP_NOR:          res = ~(in0 | in1);
      OP_SLT:          res = DATA_W'($signed(in0) < $signed(in1));
      OP_SLL, OP_SRL:  res = in1;
      OP_J, OP_JAL: begin
        res      = in1 - DATA_W'(pc) - DATA_W'(1);
        res_jump = 1'b1;
      end
      OP_LW, OP_SW:    res = in1 + imm2_x;
      OP_BEQ:          res_jump = in0 == in1;
      OP_BNE:          res_jump = in0 != in1;
      OP_LI:           res = imm4_x;
      default:         res = '0;
    endcase
  end
  // Output slot: a long shift empties it until the shifter finishes
  always_ff @(posedge clk)
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      jump      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (state == SHIFT) begin
      if (sh_done) begin
        out       <= sh_res;
        zero      <= sh_res == '0;
        jump      <= 1'b0;
        overflow  <= 1'b0;
        out_valid <= 1'b1;
      end
    end else if (accept && long_shift) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= res;
      jump      <= res_jump;
      overflow  <= ovf;
      zero      <= res == '0;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule
